// File: rtl/descrambler_pkg.sv
// descrambler_pkg: shared state encoding, field sizes and keystream tap for the 802.11 descrambler
package descrambler_pkg;
    localparam int SEED_BITS    = 7;
    localparam int SERVICE_BITS = 16;
    localparam int TAP_HI       = 6;
    localparam int TAP_LO       = 3;
    localparam logic [3:0] SEED_LAST = 4'(SEED_BITS - 1);
    localparam logic [3:0] SVC_LAST  = 4'(SERVICE_BITS - SEED_BITS - 1);

    typedef enum logic [2:0] {IDLE, SEED, SVC, DATA, DONE} state_t;

    function automatic logic keystream(input logic [SEED_BITS-1:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction
endpackage

// File: rtl/descr_lfsr.sv
// descr_lfsr: x^7+x^4+1 descrambler LFSR, loads received bits during seed recovery, free-runs otherwise
module descr_lfsr
    import descrambler_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 load_shift,
    input  logic                 step,
    input  logic                 din,
    output logic [SEED_BITS-1:0] s,
    output logic                 k
);
    assign k = keystream(s);

    // seed bits equal the keystream, so they are shifted in directly; later bits shift in k
    always_ff @(posedge clock or posedge reset)
        if (reset)           s <= '0;
        else if (clr)        s <= '0;
        else if (load_shift) s <= {s[SEED_BITS-2:0], din};
        else if (step)       s <= {s[SEED_BITS-2:0], k};
endmodule

// File: rtl/descrambler_ctrl.sv
// descrambler_ctrl: seed recovery, SERVICE skip and LSB-first PSDU byte packing; DESCRAMBLER_CTRL_SERVICE_CHECK_EN enables the SERVICE reserved-bit check
module descrambler_ctrl
    import descrambler_pkg::*;
#(
    parameter int LEN_W = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 bit_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_byte,
    output logic                 busy,
    output logic                 done,
    output logic                 service_err,
    output logic [SEED_BITS-1:0] lfsr_state
);
    state_t           state;
    logic [LEN_W-1:0] byte_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       byte_nxt;
    logic             k;
    logic             plain;
    logic             accept;

    assign in_ready = (state == SEED || state == SVC || state == DATA) && !out_valid;
    assign accept   = in_valid && in_ready;
    assign plain    = bit_in ^ k;

    descr_lfsr u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .clr        (abort || (state == IDLE && start)),
        .load_shift (accept && state == SEED),
        .step       (accept && (state == SVC || state == DATA)),
        .din        (bit_in),
        .s          (lfsr_state),
        .k          (k)
    );

    // merge the current plain bit into the partial byte at its LSB-first position
    always_comb begin
        byte_nxt = shreg;
        byte_nxt[bit_cnt[2:0]] = plain;
    end

    // frame sequencer with counters, byte packer and registered handshake/status outputs
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    byte_cnt <= len;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                    busy     <= 1'b1;
                    state    <= SEED;
                end
                SEED: if (accept) begin
                    bit_cnt <= (bit_cnt == SEED_LAST) ? 4'd0 : bit_cnt + 4'd1;
                    state   <= (bit_cnt == SEED_LAST) ? SVC : SEED;
                end
                SVC: if (accept) begin
                    if (bit_cnt == SVC_LAST) begin
                        bit_cnt <= '0;
                        state   <= (byte_cnt == '0) ? DONE : DATA;
                        done    <= (byte_cnt == '0);
                        busy    <= (byte_cnt != '0);
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                DATA: if (out_valid) begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        byte_cnt  <= byte_cnt - LEN_W'(1);
                        state     <= (byte_cnt == LEN_W'(1)) ? DONE : DATA;
                        done      <= (byte_cnt == LEN_W'(1));
                        busy      <= (byte_cnt != LEN_W'(1));
                    end
                end else if (accept) begin
                    shreg   <= byte_nxt;
                    bit_cnt <= {1'b0, bit_cnt[2:0] + 3'd1};
                    if (bit_cnt[2:0] == 3'd7) begin
                        out_byte  <= byte_nxt;
                        out_valid <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end

`ifdef DESCRAMBLER_CTRL_SERVICE_CHECK_EN
    logic svc_err_q;

    // sticky flag for any reserved SERVICE bit that descrambles to 1, cleared only by a new start
    always_ff @(posedge clock or posedge reset)
        if (reset)                             svc_err_q <= 1'b0;
        else if (abort)                        svc_err_q <= svc_err_q;
        else if (state == IDLE && start)       svc_err_q <= 1'b0;
        else if (state == SVC && accept && plain) svc_err_q <= 1'b1;

    assign service_err = svc_err_q;
`else
    assign service_err = 1'b0;
`endif
endmodule

// File: tb/tb_descrambler_ctrl.sv
// tb_descrambler_ctrl: randomized frames against a transmitter-side scrambler model
module tb_descrambler_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] len = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        bit_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        busy;
    logic        done;
    logic        service_err;
    logic [6:0]  lfsr_state;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] payload[$];

    always #5 clock = ~clock;

    descrambler_ctrl #(.LEN_W(12)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bit_in      (bit_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_byte    (out_byte),
        .busy        (busy),
        .done        (done),
        .service_err (service_err),
        .lfsr_state  (lfsr_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_lfsr"}, lfsr_state, 0);
    endtask

    // mode 0: normal, 1: abort (with simultaneous start) while third byte pending, 2: async reset mid-DATA
    task automatic run_frame(input logic [6:0] seed, input int stall, input int err_bit, input int mode);
        int n, nbits, idx, rx, wait_c, cyc, last_acc;
        bit c7, c8, did_start, got_done, acc, exp_err;
        logic hist[$];
        logic ks[$];
        logic bits[$];
        logic [6:0] s7, s8;
        logic [7:0] tmp;
        n = payload.size();
        nbits = 16 + 8 * n;
        for (int j = 6; j >= 0; j--) hist.push_back(seed[j]);
        for (int i = 0; i < nbits; i++) begin
            logic kb;
            kb = hist[hist.size() - 7] ^ hist[hist.size() - 4];
            hist.push_back(kb);
            ks.push_back(kb);
        end
        for (int i = 0; i < nbits; i++) begin
            logic p;
            if (i < 16) p = (i == err_bit);
            else begin
                tmp = payload[(i - 16) / 8];
                p = tmp[(i - 16) % 8];
            end
            bits.push_back(p ^ ks[i]);
        end
        for (int j = 0; j < 7; j++) begin
            s7[6 - j] = ks[j];
            s8[6 - j] = ks[j + 1];
        end
`ifdef DESCRAMBLER_CTRL_SERVICE_CHECK_EN
        exp_err = (err_bit >= 7);
`else
        exp_err = 1'b0;
`endif
        @(negedge clock);
        start = 1'b1;
        len = 12'(n);
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        idx = 0; rx = 0; wait_c = 0; cyc = 0; last_acc = -100;
        c7 = 0; c8 = 0; did_start = 0; got_done = 0;
        while (!got_done && cyc < 5000) begin
            if (idx == 7 && !c7) begin check("lfsr_after_seed", lfsr_state, s7); c7 = 1; end
            if (idx == 8 && !c8) begin check("lfsr_after_8", lfsr_state, s8); c8 = 1; end
            if (done) begin
                got_done = 1;
                check("done_bytes", rx, n);
                check("done_bits", idx, nbits);
                check("done_busy", busy, 0);
                check("done_valid", out_valid, 0);
                check("service_err", service_err, exp_err);
                if (n == 0) check("done_latency", cyc - last_acc, 1);
                break;
            end
            if (mode == 1 && rx == 2 && out_valid) begin
                abort = 1'b1; start = 1'b1; len = 12'd1; out_ready = 1'b0; in_valid = 1'b0;
                @(negedge clock);
                abort = 1'b0; start = 1'b0;
                check_idle_outputs("abort");
                @(negedge clock);
                check_idle_outputs("abort_stay");
                return;
            end
            if (mode == 2 && rx == 1 && idx == 16 + 8 + 4) begin
                in_valid = 1'b0; out_ready = 1'b0;
                #2 reset = 1'b1;
                #1;
                check_idle_outputs("areset");
                check("areset_byte", out_byte, 0);
                check("areset_err", service_err, 0);
                #1 reset = 1'b0;
                @(negedge clock);
                return;
            end
            if (out_valid) begin
                check("ready_while_valid", in_ready, 0);
                if (rx < n) check(wait_c == 0 ? "out_byte" : "out_byte_hold", out_byte, payload[rx]);
                else check("spurious_valid", out_valid, 0);
                out_ready = (wait_c >= stall);
                if (out_ready) begin rx++; wait_c = 0; end
                else wait_c++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            in_valid = (idx < nbits) && ($urandom_range(0, 3) != 0);
            bit_in = in_valid ? bits[idx] : 1'($urandom_range(0, 1));
            if (idx == 10 && !did_start) begin start = 1'b1; len = 12'd7; did_start = 1; end
            acc = in_valid && in_ready;
            @(posedge clock);
            if (acc) begin idx++; last_acc = cyc; end
            @(negedge clock);
            start = 1'b0;
            cyc++;
        end
        if (!got_done) check("frame_timeout", 0, 1);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        check("done_pulse_width", done, 0);
        check("idle_ready", in_ready, 0);
    endtask

    task automatic rand_payload(input int n);
        payload.delete();
        repeat (n) payload.push_back(8'($urandom));
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_idle_outputs("reset");
        check("reset_byte", out_byte, 0);
        check("reset_err", service_err, 0);
        reset = 1'b0;
        @(negedge clock);
        payload = '{8'hA5};
        run_frame(7'h7F, 0, -1, 0);
        payload = '{8'h00, 8'hFF, 8'h3C};
        run_frame(7'($urandom), 20, -1, 0);
        payload.delete();
        run_frame(7'($urandom), 0, -1, 0);
        run_frame(7'($urandom), 0, 12, 0);
        rand_payload(4);
        run_frame(7'($urandom), 0, -1, 1);
        payload = '{8'h5A};
        run_frame(7'($urandom), 0, -1, 0);
        rand_payload(2);
        run_frame(7'($urandom), 0, -1, 2);
        for (int f = 0; f < 4; f++) begin
            rand_payload($urandom_range(1, 5));
            run_frame(7'($urandom), $urandom_range(0, 3), (f == 2) ? 9 : -1, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
